// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave RAM with a write-protected vector region, wait states,
// incrementing/wrapping bursts and a side-band loader port.
module wb_ram_slave #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned ROM_WORDS   = 2,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [29:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  input  logic [2:0]  CTI_I,
  input  logic [1:0]  BTE_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        RTY_O,
  input  logic        ld_we_i,
  input  logic [29:0] ld_adr_i,
  input  logic [31:0] ld_dat_i
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [3:0]  WS_LAST = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_mem [MEM_WORDS];

  logic [29:0] r_adr;
  logic        r_we;
  logic        r_burst;
  logic        r_retry;
  logic [1:0]  r_bte;
  logic [3:0]  r_wcnt;

  logic          w_bus;
  logic          w_start;
  logic          w_oor;
  logic          w_prot;
  logic          w_term_ack;
  logic          w_term_err;
  logic          w_term_rty;
  logic          w_beat_done;
  logic          w_more;
  logic          w_bus_wr;
  logic          w_ld_hit;
  logic [AW-1:0] w_idx;
  logic [29:0]   w_adr_nxt;
  logic [31:0]   w_merged;

  assign w_bus = CYC_I & STB_I;
  // Strobes are always low in IDLE and DONE, so a new access may start from
  // either; starting from DONE keeps back-to-back classic cycles at 2+WS.
  assign w_start = w_bus & ((r_state == S_IDLE) | (r_state == S_DONE));

  assign w_idx = r_adr[AW-1:0];
  assign w_oor = |r_adr[29:AW];

  if (ROM_WORDS > 0) begin : g_prot
    assign w_prot = (r_adr < 30'(ROM_WORDS));
  end else begin : g_noprot
    assign w_prot = 1'b0;
  end

  // Termination kind of the current beat; exactly one is set.
  assign w_term_rty = r_retry;
  assign w_term_err = ~r_retry & (w_oor | (r_we & w_prot));
  assign w_term_ack = ~r_retry & ~w_term_err;

  assign ACK_O = (r_state == S_BEAT) & w_term_ack;
  assign ERR_O = (r_state == S_BEAT) & w_term_err;
  assign RTY_O = (r_state == S_BEAT) & w_term_rty;
  assign DAT_O = (ACK_O & ~r_we) ? r_mem[w_idx] : '0;

  assign w_beat_done = (r_state == S_BEAT) & w_bus;
  assign w_more      = r_burst & w_term_ack & (CTI_I == 3'b010);
  assign w_bus_wr    = w_beat_done & r_we & w_term_ack;
  assign w_ld_hit    = ld_we_i & ~|ld_adr_i[29:AW];

  // Next beat address: linear wraps at MEM_WORDS, wrap-N keeps the upper bits.
  always_comb begin
    w_adr_nxt = r_adr;
    case (r_bte)
      2'b00:   w_adr_nxt[AW-1:0] = r_adr[AW-1:0] + AW'(1);
      2'b01:   w_adr_nxt[1:0]    = r_adr[1:0] + 2'd1;
      2'b10:   w_adr_nxt[2:0]    = r_adr[2:0] + 3'd1;
      default: w_adr_nxt[3:0]    = r_adr[3:0] + 4'd1;
    endcase
  end

  // Byte-lane merge of bus write data into the addressed word.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (SEL_I[i]) w_merged[8*i +: 8] = DAT_I[8*i +: 8];
    end
  end

  // Next-state logic; a retry skips the wait states.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          if (ld_we_i || (WAIT_STATES == 0)) w_state_nxt = S_BEAT;
          else                               w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!w_bus)              w_state_nxt = S_IDLE;
        else if (r_wcnt == 4'd0) w_state_nxt = S_BEAT;
      end
      S_BEAT: begin
        if (!w_bus)       w_state_nxt = S_IDLE;
        else if (!w_more) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Access context latched at the start edge; wait counter and beat address.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_burst <= 1'b0;
      r_retry <= 1'b0;
      r_bte   <= '0;
      r_wcnt  <= '0;
    end else if (w_start) begin
      r_adr   <= ADR_I;
      r_we    <= WE_I;
      r_burst <= (CTI_I == 3'b010);
      r_retry <= ld_we_i;
      r_bte   <= BTE_I;
      r_wcnt  <= WS_LAST;
    end else if ((r_state == S_WAIT) && (r_wcnt != 4'd0)) begin
      r_wcnt <= r_wcnt - 4'd1;
    end else if (w_beat_done && w_more) begin
      r_adr <= w_adr_nxt;
    end
  end

  // Memory writes: bus write first so a same-word loader write wins.
  always_ff @(posedge CLK_I) begin
    if (w_bus_wr && !RST_I) r_mem[w_idx] <= w_merged;
    if (w_ld_hit)           r_mem[ld_adr_i[AW-1:0]] <= ld_dat_i;
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: three instances with 0, 2 and 3 wait states.
module tb_wb_ram_slave;

  localparam logic [2:0] K_ACK = 3'b100;
  localparam logic [2:0] K_ERR = 3'b010;
  localparam logic [2:0] K_RTY = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc0, cyc2, cyc3, stb, we;
  logic [29:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ld_we;
  logic [29:0] ld_adr;
  logic [31:0] ld_dat;

  logic [31:0] dat0, dat2, dat3;
  logic        ack0, err0, rty0, ack2, err2, rty2, ack3, err3, rty3;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic        mon_en   = 1'b0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] model [0:1023];

  always #5 clk = ~clk;

  wb_ram_slave #(.MEM_WORDS(1024), .ROM_WORDS(2), .WAIT_STATES(0)) u0 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc0), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte), .DAT_O(dat0), .ACK_O(ack0),
    .ERR_O(err0), .RTY_O(rty0), .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

  wb_ram_slave #(.MEM_WORDS(1024), .ROM_WORDS(2), .WAIT_STATES(2)) u2 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc2), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte), .DAT_O(dat2), .ACK_O(ack2),
    .ERR_O(err2), .RTY_O(rty2), .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

  wb_ram_slave #(.MEM_WORDS(1024), .ROM_WORDS(2), .WAIT_STATES(3)) u3 (
    .CLK_I(clk), .RST_I(rst), .CYC_I(cyc3), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .SEL_I(sel), .CTI_I(cti), .BTE_I(bte), .DAT_O(dat3), .ACK_O(ack3),
    .ERR_O(err3), .RTY_O(rty3), .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_kind(input logic w, input logic [29:0] a);
    if (a >= 30'd1024)          return K_ERR;
    else if (w && (a < 30'd2))  return K_ERR;
    else                        return K_ACK;
  endfunction

  function automatic logic [29:0] next_adr(input logic [29:0] a, input logic [1:0] b);
    logic [29:0] n;
    n = a;
    case (b)
      2'b00:   n[9:0] = a[9:0] + 10'd1;
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      default: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  // Push the expected termination for one u0 beat and update the model.
  task automatic push_beat(input logic w, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [2:0]  k;
    logic [31:0] m;
    k = exp_kind(w, a);
    if (k == K_ACK && w) begin
      m = model[a[9:0]];
      for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
      model[a[9:0]] = m;
    end
    sb_q.push_back('{kind: k, dat: ((k == K_ACK) && !w) ? model[a[9:0]] : 32'd0});
  endtask

  task automatic load(input logic [29:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_adr = a; ld_dat = d;
    model[a[9:0]] = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic wait_u0(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack0 | err0 | rty0) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("u0_timeout", 32'd0, 32'd1);
  endtask

  task automatic done_low();
    @(negedge clk);
    check("done_low", {29'd0, ack0, err0, rty0}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic classic(input logic w, input logic [29:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    int n;
    push_beat(w, a, d, s);
    cyc0 = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s; cti = 3'b000; bte = 2'b00;
    @(posedge clk);
    wait_u0(n);
    check("classic_lat", 32'(n), 32'd1);
    @(posedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0;
    done_low();
  endtask

  task automatic burst(input logic w, input logic [29:0] a, input logic [1:0] b, input int beats);
    logic [29:0] ba;
    int          n;
    int          nb;
    ba = a;
    nb = 0;
    for (int k = 0; k < beats; k++) begin
      push_beat(w, ba, 32'hB500_0000 + 32'(k), 4'hF);
      nb++;
      if (exp_kind(w, ba) != K_ACK) break;
      ba = next_adr(ba, b);
    end
    cyc0 = 1'b1; stb = 1'b1; we = w; adr = a; dat = 32'hB500_0000; sel = 4'hF;
    cti = (beats == 1) ? 3'b111 : 3'b010; bte = b;
    @(posedge clk);
    for (int k = 0; k < nb; k++) begin
      wait_u0(n);
      check("burst_gap", 32'(n), 32'd1);
      @(posedge clk); #1;
      adr = ~a;
      dat = 32'hB500_0000 + 32'(k + 1);
      if (k + 2 == beats) cti = 3'b111;
    end
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    done_low();
  endtask

  // u0 scoreboard: every strobe cycle pops one expected beat.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ack0 | err0 | rty0) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", {29'd0, ack0, err0, rty0}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_kind", {29'd0, ack0, err0, rty0}, {29'd0, mon_e.kind});
          check("sb_dat", dat0, mon_e.dat);
        end
      end else begin
        check("idle_dat", dat0, 32'd0);
      end
    end
  end

  initial begin
    #400000;
    check("watchdog", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; cyc0 = 1'b0; cyc2 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0; cti = '0; bte = '0;
    ld_we = 1'b0; ld_adr = '0; ld_dat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strb0", {29'd0, ack0, err0, rty0}, 32'd0);
    check("rst_dat0", dat0, 32'd0);
    check("rst_strb2", {29'd0, ack2, err2, rty2}, 32'd0);
    check("rst_strb3", {29'd0, ack3, err3, rty3}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Vector fetch
    load(30'd0, 32'h0000_1000);
    load(30'd1, 32'h0000_0400);
    classic(1'b0, 30'd0, 32'd0, 4'hF);
    classic(1'b0, 30'd1, 32'd0, 4'hF);

    // Byte lanes and protected region
    load(30'h10, 32'h1122_3344);
    classic(1'b1, 30'h10, 32'hAABB_CCDD, 4'b0101);
    classic(1'b0, 30'h10, 32'd0, 4'hF);
    classic(1'b1, 30'd1, 32'hDEAD_BEEF, 4'hF);
    classic(1'b1, 30'd0, 32'hDEAD_BEEF, 4'b0011);
    classic(1'b0, 30'd1, 32'd0, 4'hF);
    classic(1'b0, 30'd0, 32'd0, 4'hF);

    // Bursts: wrap-4 read, linear wrap at MEM_WORDS, out of range, wrap-8 write
    for (int i = 0; i < 4; i++) load(30'h20 + 30'(i), 32'hC0DE_0020 + 32'(i));
    burst(1'b0, 30'h23, 2'b01, 4);
    load(30'h3FE, 32'h0000_03FE);
    load(30'h3FF, 32'h0000_03FF);
    burst(1'b0, 30'h3FE, 2'b00, 3);
    burst(1'b0, 30'h7FF, 2'b00, 3);
    classic(1'b0, 30'h21, 32'd0, 4'hF);
    burst(1'b1, 30'h46, 2'b10, 3);
    classic(1'b0, 30'h46, 32'd0, 4'hF);
    classic(1'b0, 30'h47, 32'd0, 4'hF);
    classic(1'b0, 30'h40, 32'd0, 4'hF);

    // Retry: loader active at the start edge
    sb_q.push_back('{kind: K_RTY, dat: 32'd0});
    model[10'h50] = 32'h0000_0777;
    cyc0 = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd5; cti = 3'b000;
    ld_we = 1'b1; ld_adr = 30'h50; ld_dat = 32'h0000_0777;
    @(posedge clk); #1;
    ld_we = 1'b0;
    wait_u0(n);
    check("rty_lat", 32'(n), 32'd1);
    @(posedge clk); #1;
    cyc0 = 1'b0; stb = 1'b0;
    done_low();
    classic(1'b0, 30'h50, 32'd0, 4'hF);

    // Loader and bus write to the same word on the same edge: loader wins
    push_beat(1'b1, 30'h60, 32'h0000_AAAA, 4'hF);
    model[10'h60] = 32'h0000_BBBB;
    cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'h60; dat = 32'h0000_AAAA; sel = 4'hF;
    @(posedge clk); #1;
    ld_we = 1'b1; ld_adr = 30'h60; ld_dat = 32'h0000_BBBB;
    wait_u0(n);
    check("ldcol_lat", 32'(n), 32'd1);
    @(posedge clk); #1;
    ld_we = 1'b0; cyc0 = 1'b0; stb = 1'b0; we = 1'b0;
    done_low();
    classic(1'b0, 30'h60, 32'd0, 4'hF);

    // Three wait states: ACK only in cycle T+4
    cyc3 = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd1; cti = 3'b000;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("ws3_ack", {31'd0, ack3}, (i == 4) ? 32'd1 : 32'd0);
      check("ws3_dat", dat3, (i == 4) ? 32'h0000_0400 : 32'd0);
    end
    @(posedge clk); #1;
    cyc3 = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("ws3_after", {31'd0, ack3} | dat3, 32'd0);
    @(posedge clk); #1;

    // Write aborted in the wait cycle leaves memory untouched
    load(30'h30, 32'h0000_5555);
    cyc2 = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'h30; dat = 32'hFFFF_FFFF; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("abort_wait", {29'd0, ack2, err2, rty2}, 32'd0);
    cyc2 = 1'b0; stb = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {29'd0, ack2, err2, rty2}, 32'd0);
    end
    @(posedge clk); #1;
    cyc2 = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'h30;
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack2 | err2 | rty2) begin
        n = i;
        break;
      end
    end
    check("ws2_lat", 32'(n), 32'd3);
    check("ws2_ack", {31'd0, ack2}, 32'd1);
    check("abort_mem", dat2, 32'h0000_5555);
    @(posedge clk); #1;
    cyc2 = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a write burst: no commit, contents kept
    load(30'h70, 32'h1234_5678);
    sb_q.push_back('{kind: K_ACK, dat: 32'd0});
    cyc0 = 1'b1; stb = 1'b1; we = 1'b1; adr = 30'h70; dat = 32'hDEAD_0000; sel = 4'hF;
    cti = 3'b010; bte = 2'b00;
    @(posedge clk);
    wait_u0(n);
    check("rstb_lat", 32'(n), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstb_strb", {29'd0, ack0, err0, rty0}, 32'd0);
    check("rstb_dat", dat0, 32'd0);
    cyc0 = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    classic(1'b0, 30'h70, 32'd0, 4'hF);
    classic(1'b0, 30'h71, 32'd0, 4'hF);

    check("sb_left", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Synthesizable Wishbone B3 slave memory that sits directly downstream of the ao68000 bus master.
- Connects to the master's CYC/STB/WE/ADR/SEL/DAT/CTI/BTE outputs and returns DAT_I, ACK_I, ERR_I and RTY_I to the core.
- Provides word-addressed RAM with a write-protected low region holding the SSP/PC reset vectors, programmable wait states and registered-feedback incrementing bursts.
- Includes a side-band loader port so benches and boot logic can preload contents.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words; power of two, 4..65536.
- ROM_WORDS, 2, words 0..ROM_WORDS-1 are read-only from the bus; 0 disables protection.
- WAIT_STATES, 0, extra cycles inserted before the first beat of every access, 0..15.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous active-high reset.
- CYC_I  in  1  bus cycle valid.
- STB_I  in  1  strobe.
- WE_I  in  1  1=write.
- ADR_I  in  30  word address [31:2].
- DAT_I  in  32  write data.
- SEL_I  in  4  byte lane enables; bit3 = DAT[31:24].
- CTI_I  in  3  000 classic, 010 incrementing burst, 111 end of burst; other codes are treated as 000.
- BTE_I  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- DAT_O  out  32  read data.
- ACK_O  out  1  normal termination.
- ERR_O  out  1  error termination.
- RTY_O  out  1  retry termination.
- ld_we_i  in  1  loader write strobe.
- ld_adr_i  in  30  loader word address.
- ld_dat_i  in  32  loader data; full word, ignores protection.

Behaviour:
- Interface: single clock CLK_I; reset RST_I is synchronous and active-high.
- Reset: ACK_O=ERR_O=RTY_O=0, DAT_O=0, FSM=IDLE. Memory contents are not cleared. Reset asserted mid-access aborts the access with no write.
- Start condition: an access starts at an edge where CYC_I&STB_I=1 and ACK_O=ERR_O=RTY_O=0. Start address A, WE, CTI and BTE are latched at that edge.
- FSM states: IDLE, WAIT, BEAT, DONE.
  - IDLE->WAIT if WAIT_STATES>0, else IDLE->BEAT.
  - WAIT counts WAIT_STATES cycles, then enters BEAT.
  - The first termination strobe is therefore high during cycle start+1+WAIT_STATES.
  - BEAT drives exactly one of ACK/ERR/RTY.
- Beat completion: a beat completes on an edge where CYC_I&STB_I&(ACK_O|ERR_O|RTY_O). A write commits at that edge, using DAT_I and SEL_I byte lanes at the current beat address.
- Read data: DAT_O = mem[beat address] while ACK_O=1 on a read; DAT_O=0 at all other times.
- Classic (CTI=000 or 111 at start): after one completed beat go to DONE. DONE holds all strobes low for one cycle and then returns to IDLE. Back-to-back classic accesses therefore take at least 2+WAIT_STATES cycles each.
- Burst (CTI=010 at start):
  - After the first beat, ACK_O stays high with no wait states while CTI_I=010.
  - The next beat address increments the low bits per BTE: linear wraps only at MEM_WORDS; wrap-N keeps A[29:log2N] and increments modulo N.
  - ADR_I is ignored after the start.
  - A beat completed with CTI_I=111 is the last; go to DONE.
  - If CTI_I changes to any other code mid-burst, treat the current beat as last.
- Errors:
  - Beat address >= MEM_WORDS gives ERR_O in place of ACK_O, with no read or write.
  - A write to an address < ROM_WORDS gives ERR_O with no write.
  - An ERR terminates any burst (go to DONE).
  - Reads of the protected region are normal.
- Retry:
  - If ld_we_i=1 at the start edge, RTY_O pulses for one cycle and nothing is accessed (go to DONE).
  - A loader write always commits on its edge. If it hits the same word as a committing bus write in the same edge, the loader data wins.
- CYC_I or STB_I low while in WAIT or BEAT: abort, all strobes low on the next cycle, no write, go to IDLE.
- Strobe exclusivity: ACK_O, ERR_O and RTY_O are mutually exclusive and never asserted when CYC_I was low at the preceding edge.

Test Plan:
- Vector fetch: load mem[0]=0x00001000 and mem[1]=0x00000400 via the loader, then perform classic reads of ADR_I=0 and 1 -> DAT_O 0x00001000 then 0x00000400, one-cycle ACK each, ACK at start+1.
- Byte lanes: mem[0x10]=0x11223344. Write 0xAABBCCDD with SEL_I=0101, then read -> 0x11BB33DD. Write to ADR_I=1 -> ERR_O pulse, mem[1] unchanged.
- Wait states: WAIT_STATES=3, read at start edge T -> ACK_O high only in cycle T+4, DAT_O=0 outside it.
- Wrap-4 burst: read from ADR_I=0x23 with CTI=010,010,010,111 and BTE=01 -> four consecutive ACK cycles returning words 0x23,0x20,0x21,0x22, then DONE with a low cycle.
- Out-of-range linear burst: MEM_WORDS=1024, start at 0x3FE -> ACK,ACK,ERR at 0x3FE,0x3FF,0x000? No: linear wraps at MEM_WORDS, so start at 0x3FF with ADR_I bit 10 set (0x7FF) -> ERR on the first beat, FSM back in IDLE two cycles later.
- Retry and abort:
  - ld_we_i high at the start edge -> RTY_O one cycle, no ACK.
  - A separate write with WAIT_STATES=2 that drops CYC_I in the wait cycle -> no strobes, memory unchanged.
  - RST_I asserted mid-burst -> all outputs 0 on the next cycle, with contents retained.
